// File: rtl/antares_iterative_divider.sv
// Radix-2 restoring divider for the Antares execution stage.
// Accepts DIV/DIVU strobes, iterates 32 steps, returns sign-corrected quotient and remainder.
module antares_iterative_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_divs,
  input  logic        op_divu,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_stall
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_stall;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;

  logic        w_start;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;
  logic [31:0] w_dvd_in;
  logic [31:0] w_dvs_in;
  logic [31:0] w_t_hi;
  logic [32:0] w_d;

  assign w_start   = op_divs | op_divu;
  assign w_dvd_abs = dividend[31] ? (32'd0 - dividend) : dividend;
  assign w_dvs_abs = divisor[31]  ? (32'd0 - divisor)  : divisor;
  // op_divs has priority when both strobes are asserted together.
  assign w_dvd_in  = op_divs ? w_dvd_abs : dividend;
  assign w_dvs_in  = op_divs ? w_dvs_abs : divisor;

  // Upper half of {rem, quo} << 1; the partial remainder never reaches 2^31
  // before the final shift, so no bit is lost off the top.
  assign w_t_hi = {r_rem[30:0], r_quo[31]};
  assign w_d    = {1'b0, w_t_hi} - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stall <= 1'b0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_div   <= 32'd0;
      r_cnt   <= 5'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rem   <= 32'd0;
            r_quo   <= w_dvd_in;
            r_div   <= w_dvs_in;
            r_cnt   <= 5'd31;
            r_neg_q <= op_divs & (dividend[31] ^ divisor[31]);
            r_neg_r <= op_divs & dividend[31];
            r_dz    <= (divisor == 32'd0);
            r_state <= S_BUSY;
            r_stall <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!w_d[32]) begin
            r_rem <= w_d[31:0];
          end else begin
            r_rem <= w_t_hi;
          end
          r_quo <= {r_quo[30:0], ~w_d[32]};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Divide-by-zero keeps the raw iteration result: all-ones quotient, dividend magnitude.
  assign quotient  = (r_neg_q && !r_dz) ? (32'd0 - r_quo) : r_quo;
  assign remainder = (r_neg_r && !r_dz) ? (32'd0 - r_rem) : r_rem;
  assign div_stall = r_stall;

endmodule

// File: tb/tb_antares_iterative_divider.sv
// Scoreboard bench for antares_iterative_divider: directed sign/zero/busy/reset cases plus random operands.
module tb_antares_iterative_divider;

  logic        clk;
  logic        rst;
  logic        op_divs;
  logic        op_divu;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];

  antares_iterative_divider dut (
    .clk      (clk),
    .rst      (rst),
    .op_divs  (op_divs),
    .op_divu  (op_divu),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .div_stall(div_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero, as the divider must.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    longint      sa;
    longint      sbv;
    longint      lq;
    longint      lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = (sgn && a[31]) ? (32'd0 - a) : a;
    end else if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      lq  = sa / sbv;
      lr  = sa % sbv;
      q   = lq[31:0];
      r   = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Monitor: on each completed operation, pop the scoreboard and check pulse width.
  int  stall_width = 0;
  bit  prev_stall  = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      stall_width = 0;
      prev_stall  = 1'b0;
    end else begin
      if (div_stall) begin
        stall_width++;
      end else if (prev_stall) begin
        check("stall_width", stall_width, 32);
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("quotient", quotient, e[63:32]);
          check("remainder", remainder, e[31:0]);
          $display("op done: q=0x%08h r=0x%08h exp q=0x%08h r=0x%08h", quotient, remainder, e[63:32], e[31:0]);
        end
        stall_width = 0;
      end
      prev_stall = div_stall;
    end
  end

  // Call just after a posedge; strobe is sampled on the following edge.
  task automatic issue(input bit s, input bit u, input logic [31:0] a, input logic [31:0] b, input bit push);
    op_divs  = s;
    op_divu  = u;
    dividend = a;
    divisor  = b;
    if (push) sb_q.push_back(ref_div(s, a, b));
    @(posedge clk); #1;
    op_divs  = 1'b0;
    op_divu  = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      if (!div_stall) break;
      @(posedge clk); #1;
    end
    if (k == 100) check("wait_timeout", div_stall, 1'b0);
  endtask

  task automatic drain();
    wait_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    bit          u;
    rst = 1'b1; op_divs = 1'b0; op_divu = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", div_stall, 1'b0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    @(posedge clk); #1;

    // Unsigned 100/7 then hold for 10 idle cycles.
    issue(0, 1, 32'd100, 32'd7, 1);
    drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_q", quotient, 32'd14);
      check("hold_r", remainder, 32'd2);
    end
    @(posedge clk); #1;

    // Signed combinations and overflow.
    issue(1, 0, 32'hFFFF_FFF9, 32'd2, 1);         drain();
    issue(1, 0, 32'd7, 32'hFFFF_FFFE, 1);         drain();
    issue(1, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1); drain();
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();

    // Divide by zero.
    issue(0, 1, 32'h1234_5678, 32'd0, 1);        drain();
    issue(1, 0, 32'hFFFF_FFFB, 32'd0, 1);        drain();

    // Strobe during BUSY is ignored.
    issue(0, 1, 32'd100, 32'd7, 1);
    repeat (9) @(posedge clk);
    #1;
    issue(0, 1, 32'd5000, 32'd3, 0);
    drain();

    // Both strobes: signed wins, -2/2 = -1 rem 0.
    issue(1, 1, 32'hFFFF_FFFE, 32'd2, 1);
    drain();

    // Reset mid-operation aborts to reset values.
    issue(0, 1, 32'd100, 32'd7, 0);
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_stall", div_stall, 1'b0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    issue(0, 1, 32'd9, 32'd3, 1);
    drain();

    // Random back-to-back with mixed signedness; next strobe sampled at E33.
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 20);
        1: b = 32'd0 - $urandom_range(1, 20);
        2: a = $urandom_range(0, 1000);
        default: ;
      endcase
      s = $urandom_range(0, 1);
      u = s ? ($urandom_range(0, 7) == 0) : 1'b1;
      issue(s, u, a, b, 1);
      wait_idle();
    end
    drain();
    @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
